aes_sbox_arbiter: RTL and testbench
===================================

// Module: aes_sbox_arbiter
// PURPOSE
//  Shares one LANES-byte S-box lane between the round datapath and key expansion.
//  - Round requester: full 128-bit SubBytes.
//  - Key-expansion requester: 32-bit SubWord.
//  Builds LANES/4 32-bit groups of 4 Sbox instances (LANES/4 = 1, 2 or 4).
//  Round-robin arbitration, serialised beats, one-cycle done pulse per requester.
// PARAMETERS
//  LANES      4  bytes substituted per beat; legal 4, 8, 16; BEATS = 16/LANES
//  KEY_FIXED  0  0 = round-robin on tie; 1 = key requester always wins a tie
// PORTS
//  clk            in   1    single clock, rising edge
//  rst_n          in   1    reset, asynchronous assert, active-low
//  rnd_req        in   1    round request; level, held until rnd_ack
//  rnd_state_in   in   128  state to substitute; sampled only in grant cycle
//  rnd_ack        out  1    one-cycle pulse, rnd_state_out valid
//  rnd_state_out  out  128  SubBytes(rnd_state_in)
//  key_req        in   1    key request; level, held until key_ack
//  key_word_in    in   32   word to substitute; sampled only in grant cycle
//  key_ack        out  1    one-cycle pulse, key_word_out valid
//  key_word_out   out  32   SubWord(key_word_in)
//  busy           out  1    high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE, beat=0, last_grant=RND (key wins the first tie).
//   - Buffer = 0; all outputs = 0.
//   - Any in-flight transaction is discarded and no ack is issued.
//  FSM states: IDLE, RND, KEY, DONE.
//  Arbitration (IDLE only):
//   - Sole requester is granted.
//   - On a tie: if KEY_FIXED=1, grant key. Otherwise grant the side not in last_grant.
//   - On grant, capture the operand into a 128-bit buffer, update last_grant, and go to RND (beat=0) or KEY.
//  RND:
//   - Beat b substitutes buffer[LANES*8*(b+1)-1 : LANES*8*b] in place.
//   - beat increments each cycle; after beat BEATS-1 go to DONE.
//  KEY:
//   - Substitutes buffer[31:0] in one cycle, then goes to DONE.
//  DONE:
//   - Asserts the owner's ack for exactly this cycle.
//   - rnd_state_out / key_word_out are driven from the buffer.
//   - Next state is IDLE.
//  Latency, counted from the grant cycle (cycle 0):
//   - key_ack at cycle 2.
//   - rnd_ack at cycle BEATS+1 (5 for LANES=4, 2 for LANES=16).
//  Request handling:
//   - A request is sampled only in IDLE, so back-to-back transactions are separated by one IDLE cycle.
//   - req still high in the cycle after its ack is treated as a new request.
//  Non-preemptive: a granted transaction always runs to completion.
//   - A request arriving mid-transaction waits; no starvation under round-robin.
//   - req dropped before ack is a protocol violation; the transaction still completes and acks.
//  Output hold and byte mapping:
//   - Data outputs hold their last value between acks and are meaningful only while the matching ack is high.
//   - Acks of the two requesters are never high together.
//   - Byte-wise mapping: result byte n = Sbox(input byte n), positions unchanged.
// TESTING
//  1 Round, LANES=4: rnd_state_in=193de3bea0f4e22b9ac68d2ae9f84808
//    -> rnd_ack at cycle 5, out=d42711aee0bf98f1b8b45de51e415230.
//  2 Key only: key_word_in=cf4f3c09 -> key_ack at cycle 2, key_word_out=8a84eb01.
//    Also key_word_in=00000000 -> 63636363.
//  3 Tie from reset, both req in the same cycle:
//    - key granted first (ack cycle 2).
//    - Round granted in IDLE cycle 3, rnd_ack cycle 8.
//    - Next tie is won by round.
//  4 key_req rises during round beat 1 -> no effect on the round.
//    key is granted in the IDLE cycle after rnd_ack; busy high throughout the round.
//  5 rst_n low during RND beat 2 -> outputs/busy 0 immediately, no ack.
//    A new request after release completes normally.
//  6 LANES=16 and LANES=8 rerun of test 1 -> ack at cycles 2 and 3, same data.

Source files
------------

// File: rtl/aes_sbox_arbiter.sv
// Shares one LANES-byte S-box lane between round SubBytes (128-bit, serialised
// over 16/LANES beats) and key-expansion SubWord (32-bit, single beat).
//
// state | meaning
// IDLE  | arbitrate between rnd_req and key_req, capture operand on grant
// RND   | substitute one LANES-byte slice of the buffer per beat
// KEY   | substitute buffer[31:0] in one beat
// DONE  | pulse the owner's ack with the result registered on the outputs
module aes_sbox_arbiter #(
   parameter int LANES     = 4,
   parameter bit KEY_FIXED = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         rnd_req,
   input  logic [127:0] rnd_state_in,
   output logic         rnd_ack,
   output logic [127:0] rnd_state_out,
   input  logic         key_req,
   input  logic [31:0]  key_word_in,
   output logic         key_ack,
   output logic [31:0]  key_word_out,
   output logic         busy
);

   localparam int BEATS = 16 / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_RND, S_KEY, S_DONE} state_t;

   state_t          r_state;
   logic [BW-1:0]   r_beat;
   logic            r_last_key;
   logic [127:0]    r_buf;
   logic            r_busy;
   logic            r_rnd_ack;
   logic            r_key_ack;
   logic [127:0]    r_rnd_out;
   logic [31:0]     r_key_out;

   logic            w_grant_key;
   logic            w_grant_rnd;
   logic [6:0]      w_off;
   logic [LANES*8-1:0] w_lane_in;
   logic [LANES*8-1:0] w_lane_out;
   logic [127:0]    w_buf_next;

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128), then the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] inv;
      logic [7:0] b;
      sq  = a;
      inv = 8'h01;
      b   = '0;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      for (int i = 0; i < 8; i++)
         b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8];
      return b ^ 8'h63;
   endfunction

   assign w_grant_key = key_req & (~rnd_req | KEY_FIXED | ~r_last_key);
   assign w_grant_rnd = rnd_req & ~w_grant_key;

   // r_beat is always 0 in KEY, so the same slice select serves both requesters.
   assign w_off     = 7'(32'(r_beat) << $clog2(LANES*8));
   assign w_lane_in = r_buf[w_off +: LANES*8];

   for (genvar g = 0; g < LANES/4; g++) begin : g_grp
      for (genvar n = 0; n < 4; n++) begin : g_byte
         assign w_lane_out[(g*4+n)*8 +: 8] = sbox(w_lane_in[(g*4+n)*8 +: 8]);
      end
   end

   always_comb begin
      w_buf_next = r_buf;
      w_buf_next[w_off +: LANES*8] = w_lane_out;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_beat     <= '0;
         r_last_key <= 1'b0;
         r_buf      <= '0;
         r_busy     <= 1'b0;
         r_rnd_ack  <= 1'b0;
         r_key_ack  <= 1'b0;
         r_rnd_out  <= '0;
         r_key_out  <= '0;
      end else begin
         r_rnd_ack <= 1'b0;
         r_key_ack <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_beat <= '0;
               if (w_grant_key) begin
                  r_buf      <= {96'b0, key_word_in};
                  r_last_key <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= S_KEY;
               end else if (w_grant_rnd) begin
                  r_buf      <= rnd_state_in;
                  r_last_key <= 1'b0;
                  r_busy     <= 1'b1;
                  r_state    <= S_RND;
               end
            end
            S_RND: begin
               r_buf  <= w_buf_next;
               r_beat <= r_beat + 1'b1;
               if (r_beat == BW'(BEATS-1)) begin
                  r_rnd_out <= w_buf_next;
                  r_rnd_ack <= 1'b1;
                  r_state   <= S_DONE;
               end
            end
            S_KEY: begin
               r_buf[31:0] <= w_lane_out[31:0];
               r_key_out   <= w_lane_out[31:0];
               r_key_ack   <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign rnd_ack       = r_rnd_ack;
   assign key_ack       = r_key_ack;
   assign rnd_state_out = r_rnd_out;
   assign key_word_out  = r_key_out;
   assign busy          = r_busy;

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Scoreboard bench for aes_sbox_arbiter: a LANES=4 instance for arbitration and
// timing scenarios, plus LANES=8 and LANES=16 instances for the beat-count rerun.
module tb_aes_sbox_arbiter;

   localparam logic [2047:0] SBOX_TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   typedef struct {
      logic [127:0] data;
      int           at;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         rnd_req, key_req, rnd_req8, rnd_req16, key_off;
   logic [127:0] rnd_state_in;
   logic [31:0]  key_word_in;
   logic         rnd_ack, key_ack, busy;
   logic [127:0] rnd_state_out;
   logic [31:0]  key_word_out;
   logic         rnd_ack8, key_ack8, busy8, rnd_ack16, key_ack16, busy16;
   logic [127:0] rnd_state_out8, rnd_state_out16;
   logic [31:0]  key_word_out8, key_word_out16;

   int   cyc = 0;
   int   n_vec;
   int   n_err;
   exp_t rnd_q[$];
   exp_t key_q[$];

   aes_sbox_arbiter #(.LANES(4), .KEY_FIXED(1'b0)) dut (
      .clk(clk), .rst_n(rst_n),
      .rnd_req(rnd_req), .rnd_state_in(rnd_state_in), .rnd_ack(rnd_ack), .rnd_state_out(rnd_state_out),
      .key_req(key_req), .key_word_in(key_word_in), .key_ack(key_ack), .key_word_out(key_word_out),
      .busy(busy));

   aes_sbox_arbiter #(.LANES(8), .KEY_FIXED(1'b0)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .rnd_req(rnd_req8), .rnd_state_in(rnd_state_in), .rnd_ack(rnd_ack8), .rnd_state_out(rnd_state_out8),
      .key_req(key_off), .key_word_in(key_word_in), .key_ack(key_ack8), .key_word_out(key_word_out8),
      .busy(busy8));

   aes_sbox_arbiter #(.LANES(16), .KEY_FIXED(1'b0)) dut16 (
      .clk(clk), .rst_n(rst_n),
      .rnd_req(rnd_req16), .rnd_state_in(rnd_state_in), .rnd_ack(rnd_ack16), .rnd_state_out(rnd_state_out16),
      .key_req(key_off), .key_word_in(key_word_in), .key_ack(key_ack16), .key_word_out(key_word_out16),
      .busy(busy16));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [2047:0] t;
      t = SBOX_TAB;
      return t[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] x);
      logic [127:0] y;
      y = '0;
      for (int n = 0; n < 16; n++) y[n*8 +: 8] = sb(x[n*8 +: 8]);
      return y;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      logic [127:0] y;
      y = sub_bytes({96'b0, w});
      return y[31:0];
   endfunction

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_vec++; if ({rnd_ack, key_ack} !== 2'b00) begin n_err++; $display("FAIL reset_acks got=%b exp=00", {rnd_ack, key_ack}); end
      n_vec++; if (rnd_state_out !== 128'h0) begin n_err++; $display("FAIL reset_rnd_out got=%h exp=0", rnd_state_out); end
      n_vec++; if (key_word_out !== 32'h0) begin n_err++; $display("FAIL reset_key_out got=%h exp=0", key_word_out); end
      rst_n = 1'b1;
   endtask

   task automatic test_round(input logic [127:0] st, input logic [127:0] exp_out);
      exp_t e;
      int   t0;
      bit   got;
      @(negedge clk);
      rnd_state_in = st; rnd_req = 1'b1; t0 = cyc;
      rnd_q.push_back('{data: exp_out, at: t0 + 5});
      got = 1'b0;
      for (int k = 1; k <= 12 && !got; k++) begin
         @(negedge clk);
         rnd_state_in = ~st;
         if (rnd_ack) begin
            got = 1'b1; rnd_req = 1'b0;
            e = rnd_q.pop_front();
            n_vec++; if (cyc !== e.at) begin n_err++; $display("FAIL round_latency got=%0d exp=%0d", cyc - t0, e.at - t0); end
            n_vec++; if (rnd_state_out !== e.data) begin n_err++; $display("FAIL round_data got=%h exp=%h", rnd_state_out, e.data); end
         end else begin
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL round_busy cycle=%0d got=%b exp=1", cyc - t0, busy); end
         end
      end
      if (!got) begin n_vec++; n_err++; $display("FAIL round_timeout got=no_ack exp=ack"); rnd_q.delete(); rnd_req = 1'b0; end
      @(negedge clk);
      n_vec++; if ({rnd_ack, busy} !== 2'b00) begin n_err++; $display("FAIL round_after_ack got=%b exp=00", {rnd_ack, busy}); end
      n_vec++; if (rnd_state_out !== exp_out) begin n_err++; $display("FAIL round_hold got=%h exp=%h", rnd_state_out, exp_out); end
   endtask

   task automatic test_key(input logic [31:0] w, input logic [31:0] exp_out);
      exp_t e;
      int   t0;
      bit   got;
      @(negedge clk);
      key_word_in = w; key_req = 1'b1; t0 = cyc;
      key_q.push_back('{data: {96'b0, exp_out}, at: t0 + 2});
      got = 1'b0;
      for (int k = 1; k <= 8 && !got; k++) begin
         @(negedge clk);
         key_word_in = ~w;
         if (key_ack) begin
            got = 1'b1; key_req = 1'b0;
            e = key_q.pop_front();
            n_vec++; if (cyc !== e.at) begin n_err++; $display("FAIL key_latency got=%0d exp=%0d", cyc - t0, e.at - t0); end
            n_vec++; if (key_word_out !== e.data[31:0]) begin n_err++; $display("FAIL key_data got=%h exp=%h", key_word_out, e.data[31:0]); end
            n_vec++; if (rnd_ack !== 1'b0) begin n_err++; $display("FAIL key_rnd_ack got=%b exp=0", rnd_ack); end
         end
      end
      if (!got) begin n_vec++; n_err++; $display("FAIL key_timeout got=no_ack exp=ack"); key_q.delete(); key_req = 1'b0; end
   endtask

   // key_req held across its first ack: the second grant follows one IDLE cycle later.
   task automatic test_back_to_back(input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   t0;
      @(negedge clk);
      key_word_in = a; key_req = 1'b1; t0 = cyc;
      key_q.push_back('{data: {96'b0, sub_word(a)}, at: t0 + 2});
      key_q.push_back('{data: {96'b0, sub_word(b)}, at: t0 + 5});
      for (int k = 1; k <= 12 && key_q.size() > 0; k++) begin
         @(negedge clk);
         key_word_in = b;
         if (cyc == t0 + 3) begin
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle_gap got=%b exp=0", busy); end
         end
         if (key_ack) begin
            e = key_q.pop_front();
            if (key_q.size() == 0) key_req = 1'b0;
            n_vec++; if (cyc !== e.at) begin n_err++; $display("FAIL b2b_latency got=%0d exp=%0d", cyc - t0, e.at - t0); end
            n_vec++; if (key_word_out !== e.data[31:0]) begin n_err++; $display("FAIL b2b_data got=%h exp=%h", key_word_out, e.data[31:0]); end
         end
      end
      if (key_q.size() > 0) begin n_vec++; n_err++; $display("FAIL b2b_timeout got=%0d_pending exp=0", key_q.size()); key_q.delete(); end
      key_req = 1'b0;
   endtask

   // Tie from reset: key first, then round (last grant was key), then key again.
   task automatic test_tie(input logic [127:0] s, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   t0;
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      rnd_state_in = s; key_word_in = a; rnd_req = 1'b1; key_req = 1'b1; t0 = cyc;
      key_q.push_back('{data: {96'b0, sub_word(a)}, at: t0 + 2});
      rnd_q.push_back('{data: sub_bytes(s), at: t0 + 8});
      key_q.push_back('{data: {96'b0, sub_word(b)}, at: t0 + 11});
      for (int k = 1; k <= 20 && (rnd_q.size() + key_q.size()) > 0; k++) begin
         @(negedge clk);
         key_word_in = b;
         if (cyc >= t0 + 4) rnd_state_in = ~s;
         n_vec++; if ((rnd_ack & key_ack) !== 1'b0) begin n_err++; $display("FAIL tie_both_acks cycle=%0d got=1 exp=0", cyc - t0); end
         if (key_ack && key_q.size() > 0) begin
            e = key_q.pop_front();
            if (key_q.size() == 0) key_req = 1'b0;
            n_vec++; if (cyc !== e.at) begin n_err++; $display("FAIL tie_key_cycle got=%0d exp=%0d", cyc - t0, e.at - t0); end
            n_vec++; if (key_word_out !== e.data[31:0]) begin n_err++; $display("FAIL tie_key_data got=%h exp=%h", key_word_out, e.data[31:0]); end
         end
         if (rnd_ack && rnd_q.size() > 0) begin
            e = rnd_q.pop_front();
            rnd_req = 1'b0;
            n_vec++; if (cyc !== e.at) begin n_err++; $display("FAIL tie_rnd_cycle got=%0d exp=%0d", cyc - t0, e.at - t0); end
            n_vec++; if (rnd_state_out !== e.data) begin n_err++; $display("FAIL tie_rnd_data got=%h exp=%h", rnd_state_out, e.data); end
         end
      end
      if ((rnd_q.size() + key_q.size()) > 0) begin
         n_vec++; n_err++; $display("FAIL tie_timeout got=%0d_pending exp=0", rnd_q.size() + key_q.size());
         rnd_q.delete(); key_q.delete();
      end
      rnd_req = 1'b0; key_req = 1'b0;
   endtask

   // key_req rises during round beat 1; the round is unaffected and key waits.
   task automatic test_mid_key(input logic [127:0] s, input logic [31:0] w);
      exp_t e;
      int   t0;
      @(negedge clk);
      rnd_state_in = s; rnd_req = 1'b1; t0 = cyc;
      rnd_q.push_back('{data: sub_bytes(s), at: t0 + 5});
      key_q.push_back('{data: {96'b0, sub_word(w)}, at: t0 + 8});
      for (int k = 1; k <= 14 && (rnd_q.size() + key_q.size()) > 0; k++) begin
         @(negedge clk);
         rnd_state_in = ~s;
         if (k == 2) begin key_word_in = w; key_req = 1'b1; end
         if (k <= 5) begin
            n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy cycle=%0d got=%b exp=1", k, busy); end
         end
         if (k == 6) begin
            n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_idle cycle=6 got=%b exp=0", busy); end
         end
         if (rnd_ack && rnd_q.size() > 0) begin
            e = rnd_q.pop_front(); rnd_req = 1'b0;
            n_vec++; if (cyc !== e.at) begin n_err++; $display("FAIL mid_rnd_cycle got=%0d exp=%0d", cyc - t0, e.at - t0); end
            n_vec++; if (rnd_state_out !== e.data) begin n_err++; $display("FAIL mid_rnd_data got=%h exp=%h", rnd_state_out, e.data); end
         end
         if (key_ack && key_q.size() > 0) begin
            e = key_q.pop_front(); key_req = 1'b0;
            n_vec++; if (cyc !== e.at) begin n_err++; $display("FAIL mid_key_cycle got=%0d exp=%0d", cyc - t0, e.at - t0); end
            n_vec++; if (key_word_out !== e.data[31:0]) begin n_err++; $display("FAIL mid_key_data got=%h exp=%h", key_word_out, e.data[31:0]); end
         end
      end
      if ((rnd_q.size() + key_q.size()) > 0) begin
         n_vec++; n_err++; $display("FAIL mid_timeout got=%0d_pending exp=0", rnd_q.size() + key_q.size());
         rnd_q.delete(); key_q.delete();
      end
      rnd_req = 1'b0; key_req = 1'b0;
   endtask

   // Reset during round beat 2 clears everything at once and no ack follows.
   task automatic test_reset_mid(input logic [127:0] s);
      int spurious;
      @(negedge clk);
      rnd_state_in = s; rnd_req = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_pre_busy got=%b exp=1", busy); end
      rst_n = 1'b0;
      #1;
      n_vec++; if ({busy, rnd_ack, key_ack} !== 3'b000) begin n_err++; $display("FAIL rmid_flags got=%b exp=000", {busy, rnd_ack, key_ack}); end
      n_vec++; if ({rnd_state_out, key_word_out} !== 160'h0) begin n_err++; $display("FAIL rmid_outputs got=%h exp=0", {rnd_state_out, key_word_out}); end
      rnd_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (rnd_ack || busy) spurious++;
      end
      n_vec++; if (spurious !== 0) begin n_err++; $display("FAIL rmid_no_ack got=%0d exp=0", spurious); end
   endtask

   task automatic test_lanes(input logic [127:0] st, input logic [127:0] exp_out);
      int t0;
      bit got8, got16;
      @(negedge clk);
      rnd_state_in = st; rnd_req8 = 1'b1; rnd_req16 = 1'b1; t0 = cyc;
      got8 = 1'b0; got16 = 1'b0;
      for (int k = 1; k <= 8 && !(got8 && got16); k++) begin
         @(negedge clk);
         rnd_state_in = ~st;
         if (k == 1) begin
            n_vec++; if ({busy8, busy16} !== 2'b11) begin n_err++; $display("FAIL lanes_busy got=%b exp=11", {busy8, busy16}); end
         end
         if (rnd_ack8 && !got8) begin
            got8 = 1'b1; rnd_req8 = 1'b0;
            n_vec++; if (cyc !== t0 + 3) begin n_err++; $display("FAIL lanes8_latency got=%0d exp=3", cyc - t0); end
            n_vec++; if (rnd_state_out8 !== exp_out) begin n_err++; $display("FAIL lanes8_data got=%h exp=%h", rnd_state_out8, exp_out); end
         end
         if (rnd_ack16 && !got16) begin
            got16 = 1'b1; rnd_req16 = 1'b0;
            n_vec++; if (cyc !== t0 + 2) begin n_err++; $display("FAIL lanes16_latency got=%0d exp=2", cyc - t0); end
            n_vec++; if (rnd_state_out16 !== exp_out) begin n_err++; $display("FAIL lanes16_data got=%h exp=%h", rnd_state_out16, exp_out); end
         end
      end
      if (!(got8 && got16)) begin n_vec++; n_err++; $display("FAIL lanes_timeout got=%b%b exp=11", got8, got16); end
      rnd_req8 = 1'b0; rnd_req16 = 1'b0;
      @(negedge clk);
      n_vec++;
      if ({key_ack8, key_ack16, key_word_out8, key_word_out16} !== 66'h0) begin
         n_err++; $display("FAIL lanes_key_side got=%h exp=0", {key_ack8, key_ack16, key_word_out8, key_word_out16});
      end
   endtask

   initial begin
      logic [127:0] rv;
      logic [31:0]  kw;
      n_vec = 0; n_err = 0;
      rnd_req = 1'b0; key_req = 1'b0; rnd_req8 = 1'b0; rnd_req16 = 1'b0; key_off = 1'b0;
      rnd_state_in = '0; key_word_in = '0;
      test_reset;
      test_round(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);
      rv = {$urandom, $urandom, $urandom, $urandom};
      test_round(rv, sub_bytes(rv));
      test_key(32'hcf4f3c09, 32'h8a84eb01);
      test_key(32'h00000000, 32'h63636363);
      kw = $urandom;
      test_key(kw, sub_word(kw));
      test_back_to_back($urandom, $urandom);
      test_tie({$urandom, $urandom, $urandom, $urandom}, $urandom, $urandom);
      test_mid_key({$urandom, $urandom, $urandom, $urandom}, $urandom);
      test_reset_mid({$urandom, $urandom, $urandom, $urandom});
      rv = {$urandom, $urandom, $urandom, $urandom};
      test_round(rv, sub_bytes(rv));
      test_lanes(128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
